ysyx_23060077_riscv_id_ex_buf: RTL

Decode-to-execute pipeline buffer for the ysyx_23060077 core. It captures the decoded bundle produced by the ID stage (alu_opt, src_sel, lsu_opt plus operands) under a valid/ready handshake. It presents the bundle to the EXU and decouples the two stages. It supports stall back-pressure, branch/trap flush and an optional skid entry that removes the combinational ready path from EXU to IDU.

---
 rtl/ysyx_23060077_riscv_id_ex_buf.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060077_riscv_id_ex_buf.sv
// ID->EX pipeline buffer: valid/ready handshake, flush, stall cycle counter.
// Define ID_EX_SKID_EN to add a skid entry so id_ready comes from a register.
`ifndef ALU_OPT_WIDTH
`define ALU_OPT_WIDTH 4
`endif
`ifndef SRC_SEL_WIDTH
`define SRC_SEL_WIDTH 2
`endif
`ifndef LSU_OPT_WIDTH
`define LSU_OPT_WIDTH 3
`endif
`ifndef ALU_SRA
`define ALU_SRA 4'd7
`endif
`ifndef SRC_SEL_RS1_IMM
`define SRC_SEL_RS1_IMM 2'd1
`endif
`ifndef LSU_OPT_STORE
`define LSU_OPT_STORE 3'd2
`endif

module ysyx_23060077_riscv_id_ex_buf #(
    parameter int DATA_WIDTH      = 32,
    parameter int STALL_CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       id_valid,
    output logic                       id_ready,
    input  logic [DATA_WIDTH-1:0]      id_pc,
    input  logic [DATA_WIDTH-1:0]      id_rs1_data,
    input  logic [DATA_WIDTH-1:0]      id_rs2_data,
    input  logic [DATA_WIDTH-1:0]      id_imm,
    input  logic [4:0]                 id_rd,
    input  logic                       id_rd_wen,
    input  logic [2:0]                 id_funct3,
    input  logic [`ALU_OPT_WIDTH-1:0]  id_alu_opt,
    input  logic [`SRC_SEL_WIDTH-1:0]  id_src_sel,
    input  logic [`LSU_OPT_WIDTH-1:0]  id_lsu_opt,
    output logic                       ex_valid,
    input  logic                       ex_ready,
    output logic [DATA_WIDTH-1:0]      ex_pc,
    output logic [DATA_WIDTH-1:0]      ex_rs1_data,
    output logic [DATA_WIDTH-1:0]      ex_rs2_data,
    output logic [DATA_WIDTH-1:0]      ex_imm,
    output logic [4:0]                 ex_rd,
    output logic                       ex_rd_wen,
    output logic [2:0]                 ex_funct3,
    output logic [`ALU_OPT_WIDTH-1:0]  ex_alu_opt,
    output logic [`SRC_SEL_WIDTH-1:0]  ex_src_sel,
    output logic [`LSU_OPT_WIDTH-1:0]  ex_lsu_opt,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     pc;
        logic [DATA_WIDTH-1:0]     rs1_data;
        logic [DATA_WIDTH-1:0]     rs2_data;
        logic [DATA_WIDTH-1:0]     imm;
        logic [4:0]                rd;
        logic                      rd_wen;
        logic [2:0]                funct3;
        logic [`ALU_OPT_WIDTH-1:0] alu_opt;
        logic [`SRC_SEL_WIDTH-1:0] src_sel;
        logic [`LSU_OPT_WIDTH-1:0] lsu_opt;
    } bundle_t;

    bundle_t id_b, out_q, out_d;
    logic    out_v_q, out_v_d;
    logic    accept, issue;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;

    assign id_b = '{pc: id_pc, rs1_data: id_rs1_data, rs2_data: id_rs2_data,
                    imm: id_imm, rd: id_rd, rd_wen: id_rd_wen, funct3: id_funct3,
                    alu_opt: id_alu_opt, src_sel: id_src_sel, lsu_opt: id_lsu_opt};

    assign accept = id_valid & id_ready;
    assign issue  = out_v_q & ex_ready;

`ifdef ID_EX_SKID_EN
    bundle_t sk_q, sk_d;
    logic    sk_v_q, sk_v_d;

    // Registered ready: the skid slot absorbs the beat that arrives while EXU stalls.
    assign id_ready = ~sk_v_q;

    always_comb begin
        out_d   = out_q;
        out_v_d = out_v_q;
        sk_d    = sk_q;
        sk_v_d  = sk_v_q;
        if (!out_v_q || issue) begin
            if (sk_v_q) begin
                out_d   = sk_q;
                out_v_d = 1'b1;
                sk_v_d  = 1'b0;
            end else if (accept) begin
                out_d   = id_b;
                out_v_d = 1'b1;
            end else begin
                out_v_d = 1'b0;
            end
        end else if (accept) begin
            sk_d   = id_b;
            sk_v_d = 1'b1;
        end
        if (flush) begin
            out_v_d = 1'b0;
            sk_v_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sk_q   <= '0;
            sk_v_q <= 1'b0;
        end else begin
            sk_q   <= sk_d;
            sk_v_q <= sk_v_d;
        end
    end
`else
    assign id_ready = ~out_v_q | ex_ready;

    always_comb begin
        out_d   = out_q;
        out_v_d = out_v_q;
        if (!out_v_q || issue) begin
            out_v_d = accept;
            if (accept) out_d = id_b;
        end
        if (flush) out_v_d = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_v_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            out_q   <= out_d;
            out_v_q <= out_v_d;
            if (out_v_q && !ex_ready)
                stall_cnt_q <= stall_cnt_q + {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign ex_valid    = out_v_q;
    assign ex_pc       = out_q.pc;
    assign ex_rs1_data = out_q.rs1_data;
    assign ex_rs2_data = out_q.rs2_data;
    assign ex_imm      = out_q.imm;
    assign ex_rd       = out_q.rd;
    assign ex_rd_wen   = out_q.rd_wen;
    assign ex_funct3   = out_q.funct3;
    assign ex_alu_opt  = out_q.alu_opt;
    assign ex_src_sel  = out_q.src_sel;
    assign ex_lsu_opt  = out_q.lsu_opt;
    assign stall_cnt   = stall_cnt_q;

endmodule
